// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts 1s per channel over a window of 2**LEN_LOG2 valid samples.
// Optional overlap counter of bits_in[0] & bits_in[1] enabled by SC_DEC_OVERLAP_CNT_EN.
module sc_stream_decoder #(
    parameter int NUM_CH   = 1,
    parameter int LEN_LOG2 = 8
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              in_valid,
    input  logic [NUM_CH-1:0]                 bits_in,
    output logic                              busy,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [NUM_CH*(LEN_LOG2+1)-1:0]    counts_out
`ifdef SC_DEC_OVERLAP_CNT_EN
    ,
    output logic [LEN_LOG2:0]                 and_count
`endif
);

    localparam int CW = LEN_LOG2 + 1;

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t              state;
    logic [CW-1:0]       acc [NUM_CH];
    logic [LEN_LOG2-1:0] sample_ctr;
    logic                last_sample;
    logic                handshake;

    assign last_sample = in_valid && (sample_ctr == '1);
    assign handshake   = out_valid && out_ready;

`ifdef SC_DEC_OVERLAP_CNT_EN
    if (NUM_CH < 2) begin : g_overlap_needs_two_channels
        $error("sc_stream_decoder: SC_DEC_OVERLAP_CNT_EN requires NUM_CH >= 2");
    end

    logic [CW-1:0] and_acc;
    logic          and_bit;

    assign and_bit = bits_in[0] & bits_in[1];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            counts_out <= '0;
            sample_ctr <= '0;
            for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
`ifdef SC_DEC_OVERLAP_CNT_EN
            and_acc    <= '0;
            and_count  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= ACCUM;
                        busy       <= 1'b1;
                        sample_ctr <= '0;
                        for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
`ifdef SC_DEC_OVERLAP_CNT_EN
                        and_acc    <= '0;
`endif
                    end
                end

                ACCUM: begin
                    // Abort wins over a coincident last sample; that cycle's bits are dropped.
                    if (start) begin
                        sample_ctr <= '0;
                        for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
`ifdef SC_DEC_OVERLAP_CNT_EN
                        and_acc    <= '0;
`endif
                    end else if (last_sample) begin
                        state      <= HOLD;
                        busy       <= 1'b0;
                        out_valid  <= 1'b1;
                        sample_ctr <= '0;
                        for (int k = 0; k < NUM_CH; k++)
                            counts_out[k*CW +: CW] <= acc[k] + CW'(bits_in[k]);
`ifdef SC_DEC_OVERLAP_CNT_EN
                        and_count  <= and_acc + CW'(and_bit);
`endif
                    end else if (in_valid) begin
                        sample_ctr <= sample_ctr + LEN_LOG2'(1);
                        for (int k = 0; k < NUM_CH; k++)
                            acc[k] <= acc[k] + CW'(bits_in[k]);
`ifdef SC_DEC_OVERLAP_CNT_EN
                        and_acc    <= and_acc + CW'(and_bit);
`endif
                    end
                end

                HOLD: begin
                    // A start without a handshake is ignored so the result is never lost.
                    if (handshake) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            state      <= ACCUM;
                            busy       <= 1'b1;
                            sample_ctr <= '0;
                            for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
`ifdef SC_DEC_OVERLAP_CNT_EN
                            and_acc    <= '0;
`endif
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sc_stream_decoder.sv
// Self-checking bench for sc_stream_decoder (NUM_CH=2, LEN_LOG2=4): directed cases plus
// random traffic compared every cycle against a window-level behavioural model.
module tb_sc_stream_decoder;

    localparam int NUM_CH   = 2;
    localparam int LEN_LOG2 = 4;
    localparam int CW       = LEN_LOG2 + 1;
    localparam int WIN      = 1 << LEN_LOG2;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    start = 1'b0;
    logic                    in_valid = 1'b0;
    logic [NUM_CH-1:0]       bits_in = '0;
    logic                    out_ready = 1'b0;
    logic                    busy;
    logic                    out_valid;
    logic [NUM_CH*CW-1:0]    counts_out;
`ifdef SC_DEC_OVERLAP_CNT_EN
    logic [CW-1:0]           and_count;
`endif

    int vectors = 0;
    int miscompares = 0;

    sc_stream_decoder #(.NUM_CH(NUM_CH), .LEN_LOG2(LEN_LOG2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .bits_in(bits_in),
        .busy(busy), .out_valid(out_valid), .out_ready(out_ready), .counts_out(counts_out)
`ifdef SC_DEC_OVERLAP_CNT_EN
        , .and_count(and_count)
`endif
    );

    always #5 clk = ~clk;

    // Window-level model: a window is open, a result is pending, or neither.
    logic               m_open, m_pend;
    int                 m_n;
    int                 m_sum [NUM_CH];
    logic [NUM_CH*CW-1:0] m_counts;
    int                 m_and;
    logic [CW-1:0]      m_and_res;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_open <= 1'b0; m_pend <= 1'b0; m_n <= 0; m_counts <= '0;
            m_and <= 0; m_and_res <= '0;
            for (int k = 0; k < NUM_CH; k++) m_sum[k] <= 0;
        end else if (m_pend) begin
            if (out_ready) begin
                m_pend <= 1'b0;
                if (start) begin
                    m_open <= 1'b1; m_n <= 0; m_and <= 0;
                    for (int k = 0; k < NUM_CH; k++) m_sum[k] <= 0;
                end
            end
        end else if (!m_open) begin
            if (start) begin
                m_open <= 1'b1; m_n <= 0; m_and <= 0;
                for (int k = 0; k < NUM_CH; k++) m_sum[k] <= 0;
            end
        end else if (start) begin
            m_n <= 0; m_and <= 0;
            for (int k = 0; k < NUM_CH; k++) m_sum[k] <= 0;
        end else if (in_valid) begin
            if (m_n + 1 == WIN) begin
                for (int k = 0; k < NUM_CH; k++)
                    m_counts[k*CW +: CW] <= CW'(m_sum[k] + int'(bits_in[k]));
                m_and_res <= CW'(m_and + int'(bits_in[0] & bits_in[1]));
                m_open <= 1'b0; m_pend <= 1'b1; m_n <= 0;
            end else begin
                m_n <= m_n + 1;
                m_and <= m_and + int'(bits_in[0] & bits_in[1]);
                for (int k = 0; k < NUM_CH; k++) m_sum[k] <= m_sum[k] + int'(bits_in[k]);
            end
        end
    end

    always @(negedge clk) begin
        vectors++;
        if (busy !== m_open || out_valid !== m_pend || counts_out !== m_counts) begin
            miscompares++;
            $display("FAIL cycle_compare t=%0t actual busy=%b out_valid=%b counts=%h required busy=%b out_valid=%b counts=%h",
                     $time, busy, out_valid, counts_out, m_open, m_pend, m_counts);
        end
`ifdef SC_DEC_OVERLAP_CNT_EN
        vectors++;
        if (and_count !== m_and_res) begin
            miscompares++;
            $display("FAIL and_compare t=%0t actual %0d required %0d", $time, and_count, m_and_res);
        end
`endif
    end

    task automatic chk(input string nm, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s actual %0d required %0d", nm, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge and are held for one full cycle.
    task automatic drive(input logic s, input logic v, input logic [NUM_CH-1:0] b, input logic r);
        start = s; in_valid = v; bits_in = b; out_ready = r;
        @(posedge clk);
        #1;
    endtask

    function automatic int ch(input int k);
        return int'(counts_out[k*CW +: CW]);
    endfunction

    initial begin
        int nv, c;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_counts", int'(counts_out), 0);
        rst_n = 1'b1;
        drive(0, 1, 2'b11, 0);
        chk("idle_ignores_valid", int'(busy), 0);

        // Constant streams: ch0 all ones, ch1 all zeros.
        drive(1, 0, 2'b00, 0);
        chk("start_busy", int'(busy), 1);
        for (int i = 0; i < WIN; i++) begin
            drive(0, 1, 2'b01, 0);
            if (i == WIN - 2) chk("no_early_valid", int'(out_valid), 0);
        end
        chk("full_window_valid", int'(out_valid), 1);
        chk("full_window_ch0", ch(0), 16);
        chk("full_window_ch1", ch(1), 0);
        chk("hold_not_busy", int'(busy), 0);
        drive(0, 0, 2'b00, 1);
        chk("handshake_clears", int'(out_valid), 0);

        // Alternating ch0 with a stall on every third cycle.
        drive(1, 0, 2'b00, 0);
        nv = 0; c = 0;
        while (nv < WIN) begin
            c++;
            if (c % 3 == 0) drive(0, 0, NUM_CH'($urandom), 0);
            else begin
                drive(0, 1, {1'($urandom), (nv % 2 == 0)}, 0);
                nv++;
            end
        end
        chk("stall_window_valid", int'(out_valid), 1);
        chk("stall_window_ch0", ch(0), 8);
        drive(0, 0, 2'b00, 1);

        // Abort after 7 samples, then a clean window.
        drive(1, 0, 2'b00, 0);
        for (int i = 0; i < 7; i++) drive(0, 1, NUM_CH'($urandom), 0);
        drive(1, 1, 2'b11, 0);
        for (int i = 0; i < WIN; i++) drive(0, 1, {1'($urandom), 1'b1}, 0);
        chk("abort_ch0", ch(0), 16);
        drive(0, 0, 2'b00, 1);

        // Abort coinciding with the last sample must not complete the window.
        drive(1, 0, 2'b00, 0);
        for (int i = 0; i < WIN - 1; i++) drive(0, 1, 2'b01, 0);
        drive(1, 1, 2'b11, 0);
        chk("abort_last_no_valid", int'(out_valid), 0);
        chk("abort_last_busy", int'(busy), 1);
        for (int i = 0; i < WIN; i++) drive(0, 1, 2'b10, 0);
        chk("abort_last_counts", int'(counts_out), 16 << CW);

        // Backpressure with an ignored start.
        for (int i = 0; i < 5; i++) drive(i == 2, 0, 2'b00, 0);
        chk("bp_valid_held", int'(out_valid), 1);
        chk("bp_counts_stable", int'(counts_out), 16 << CW);
        chk("bp_start_ignored", int'(busy), 0);

        // Handshake and start in the same cycle.
        drive(1, 0, 2'b00, 1);
        chk("hs_start_busy", int'(busy), 1);
        chk("hs_start_valid_low", int'(out_valid), 0);
        chk("counts_hold_in_accum", int'(counts_out), 16 << CW);
        for (int i = 0; i < WIN; i++) drive(0, 1, 2'b11, 0);
        chk("hs_start_second_valid", int'(out_valid), 1);
        chk("all_ones_counts", int'(counts_out), (16 << CW) | 16);
        drive(0, 0, 2'b00, 1);

`ifdef SC_DEC_OVERLAP_CNT_EN
        drive(1, 0, 2'b00, 0);
        for (int i = 0; i < WIN; i++) drive(0, 1, (i < 5) ? 2'b11 : 2'b01, 0);
        chk("overlap_and_count", int'(and_count), 5);
        drive(0, 0, 2'b00, 1);
`endif

        // Asynchronous reset in the middle of a window.
        drive(1, 0, 2'b00, 0);
        for (int i = 0; i < 9; i++) drive(0, 1, 2'b11, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("midreset_busy", int'(busy), 0);
        chk("midreset_valid", int'(out_valid), 0);
        chk("midreset_counts", int'(counts_out), 0);
        repeat (2) drive(0, 1, 2'b11, 1);
        rst_n = 1'b1;
        for (int i = 0; i < WIN; i++) drive(0, 1, 2'b11, 1);
        chk("post_reset_no_valid", int'(out_valid), 0);

        // Random traffic, checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++)
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
                  NUM_CH'($urandom), 1'($urandom));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
